// File: rtl/pipe_stage_skid_reg_if.sv
// Handshake bundle for one pipeline stage with a skid register: upstream
// offer/accept, downstream offer/accept, flush and the stage status outputs.
interface pipe_stage_skid_reg_if #(
   parameter int DATA_W = 128,
   parameter int CTRL_W = 16
);
   logic              flush;
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_data;
   logic [CTRL_W-1:0] in_ctrl;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;
   logic [CTRL_W-1:0] out_ctrl;
   logic [1:0]        occupancy;
   logic [15:0]       flush_drops;

   // Stage side: consumes the upstream offer and downstream ready.
   modport slave (
      input  flush, in_valid, in_data, in_ctrl, out_ready,
      output in_ready, out_valid, out_data, out_ctrl, occupancy, flush_drops
   );

   // Driver side: the neighbouring stages (or a bench).
   modport master (
      output flush, in_valid, in_data, in_ctrl, out_ready,
      input  in_ready, out_valid, out_data, out_ctrl, occupancy, flush_drops
   );
endinterface

// File: rtl/pipe_stage_skid_reg.sv
// Pipeline stage register with a one-entry skid buffer. The main register
// drives the outputs; the skid register catches the entry accepted while the
// downstream stalls, so in_ready depends only on stored state.
module pipe_stage_skid_reg #(
   parameter int                 DATA_W   = 128,
   parameter int                 CTRL_W   = 16,
   parameter logic [CTRL_W-1:0]  CTRL_NOP = '0
) (
   input logic                  clk,
   input logic                  rst,
   pipe_stage_skid_reg_if.slave bus
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } state_t;

   state_t            state_q, state_nxt;
   logic [DATA_W-1:0] main_data_p1, main_data_nxt;
   logic [CTRL_W-1:0] main_ctrl_p1, main_ctrl_nxt;
   logic [DATA_W-1:0] skid_data_p0, skid_data_nxt;
   logic [CTRL_W-1:0] skid_ctrl_p0, skid_ctrl_nxt;
   logic [15:0]       drops_q, drops_nxt;
   logic              vld_p1;
   logic              in_fire;
   logic              out_fire;
   logic [2:0]        lost_cnt;

   // Add a small count to the drop counter, pinning at all-ones.
   function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [2:0] b);
      logic [16:0] s;
      s = {1'b0, a} + {14'b0, b};
      return s[16] ? 16'hFFFF : s[15:0];
   endfunction

   assign vld_p1   = (state_q != EMPTY);
   assign in_fire  = bus.in_valid && (state_q != FULL);
   assign out_fire = vld_p1 && bus.out_ready;

   // Entries lost to a flush: stored ones not leaving this cycle, plus an
   // input that would otherwise have been accepted.
   assign lost_cnt = {1'b0, state_q} - {2'b0, out_fire} + {2'b0, in_fire};

   // Next state and register contents; flush overrides normal transitions.
   always_comb begin
      state_nxt     = state_q;
      main_data_nxt = main_data_p1;
      main_ctrl_nxt = main_ctrl_p1;
      skid_data_nxt = skid_data_p0;
      skid_ctrl_nxt = skid_ctrl_p0;
      drops_nxt     = drops_q;
      if (bus.flush) begin
         state_nxt     = EMPTY;
         main_data_nxt = '0;
         main_ctrl_nxt = CTRL_NOP;
         skid_data_nxt = '0;
         skid_ctrl_nxt = CTRL_NOP;
         drops_nxt     = sat_add16(drops_q, lost_cnt);
      end else begin
         unique case (state_q)
            EMPTY: begin
               if (in_fire) begin
                  state_nxt     = ONE;
                  main_data_nxt = bus.in_data;
                  main_ctrl_nxt = bus.in_ctrl;
               end
            end
            ONE: begin
               if (in_fire && out_fire) begin
                  main_data_nxt = bus.in_data;
                  main_ctrl_nxt = bus.in_ctrl;
               end else if (in_fire) begin
                  state_nxt     = FULL;
                  skid_data_nxt = bus.in_data;
                  skid_ctrl_nxt = bus.in_ctrl;
               end else if (out_fire) begin
                  state_nxt     = EMPTY;
                  main_data_nxt = '0;
                  main_ctrl_nxt = CTRL_NOP;
               end
            end
            FULL: begin
               if (out_fire) begin
                  state_nxt     = ONE;
                  main_data_nxt = skid_data_p0;
                  main_ctrl_nxt = skid_ctrl_p0;
                  skid_data_nxt = '0;
                  skid_ctrl_nxt = CTRL_NOP;
               end
            end
            default: begin
               state_nxt     = EMPTY;
               main_data_nxt = '0;
               main_ctrl_nxt = CTRL_NOP;
               skid_data_nxt = '0;
               skid_ctrl_nxt = CTRL_NOP;
            end
         endcase
      end
   end

   // State, storage and drop counter; reset clears everything to a bubble.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q      <= EMPTY;
         main_data_p1 <= '0;
         main_ctrl_p1 <= CTRL_NOP;
         skid_data_p0 <= '0;
         skid_ctrl_p0 <= CTRL_NOP;
         drops_q      <= '0;
      end else begin
         state_q      <= state_nxt;
         main_data_p1 <= main_data_nxt;
         main_ctrl_p1 <= main_ctrl_nxt;
         skid_data_p0 <= skid_data_nxt;
         skid_ctrl_p0 <= skid_ctrl_nxt;
         drops_q      <= drops_nxt;
      end
   end

   // Output stage: everything below is a flop or a decode of the state flop.
   assign bus.in_ready    = (state_q != FULL);
   assign bus.out_valid   = vld_p1;
   assign bus.out_data    = main_data_p1;
   assign bus.out_ctrl    = main_ctrl_p1;
   assign bus.occupancy   = state_q;
   assign bus.flush_drops = drops_q;

endmodule
